// File: rtl/wb_host_master.sv
// wb_host_master
// Bridges a UART byte stream to Wishbone so that a host can act as a second
// bus initiator. It runs 32-bit single-beat reads ('R' A3..A0) and writes
// ('W' A3..A0 D3..D0), with multi-byte fields sent MSB first. A read replies
// with D3..D0, a write replies with 'K', and a bus timeout replies with 'E'.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready    command byte input (valid/ready)
//   tx_data/tx_valid/tx_ready    reply byte output (valid/ready)
//   adr_o, dat_o, dat_i, sel_o,
//   we_o, cyc_o, stb_o, ack_i    Wishbone initiator port
//   busy                         high whenever the FSM is not idle
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | wait for 'R'/'W'; any other byte is consumed and dropped
// ADDR  | shift in the 4 address bytes
// DATA  | shift in the 4 write-data bytes (writes only)
// BUS   | cyc/stb asserted until ack or timeout
// RESP  | send the reply bytes, one per 2 cycles at most
module wb_host_master #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic        r_we, r_we_o, r_cyc, r_ok, r_busy, r_tx_valid;
  logic [1:0]  r_cnt;
  logic [15:0] r_tmo;
  logic [31:0] r_adr, r_wdat, r_resp;
  logic [7:0]  r_tx_data;

  logic w_rx_hs, w_tx_hs, w_resp_last, w_cmd;

  assign rx_ready = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign sel_o    = (r_state == S_BUS) ? 4'hf : 4'h0;
  assign adr_o    = r_adr;
  assign dat_o    = r_wdat;
  assign we_o     = r_we_o;
  assign cyc_o    = r_cyc;
  assign stb_o    = r_cyc;
  assign busy     = r_busy;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;

  assign w_rx_hs = rx_valid & rx_ready;
  assign w_tx_hs = r_tx_valid & tx_ready;
  assign w_cmd   = (rx_data == 8'h52) || (rx_data == 8'h57);
  // Only a successful read has more than one reply byte.
  assign w_resp_last = !r_ok || r_we || (r_cnt == 2'd3);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_rx_hs && w_cmd) w_next = S_ADDR;
      S_ADDR: if (w_rx_hs && r_cnt == 2'd3) w_next = r_we ? S_DATA : S_BUS;
      S_DATA: if (w_rx_hs && r_cnt == 2'd3) w_next = S_BUS;
      S_BUS:  if (ack_i || r_tmo == TMO_LAST) w_next = S_RESP;
      S_RESP: if (w_tx_hs && w_resp_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we       <= 1'b0;
      r_we_o     <= 1'b0;
      r_cyc      <= 1'b0;
      r_ok       <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_valid <= 1'b0;
      r_cnt      <= 2'd0;
      r_tmo      <= 16'd0;
      r_adr      <= 32'd0;
      r_wdat     <= 32'd0;
      r_resp     <= 32'd0;
      r_tx_data  <= 8'd0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_next == S_ADDR) begin
            r_we  <= (rx_data == 8'h57);
            r_cnt <= 2'd0;
          end
        end
        S_ADDR: begin
          if (w_rx_hs) begin
            // The last address byte carries A[1:0], which are forced to 0.
            if (r_cnt == 2'd3) r_adr <= {r_adr[23:0], rx_data[7:2], 2'b00};
            else               r_adr <= {r_adr[23:0], rx_data};
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (w_rx_hs) begin
            r_wdat <= {r_wdat[23:0], rx_data};
            r_cnt  <= r_cnt + 2'd1;
          end
        end
        S_BUS: begin
          r_tmo <= r_tmo + 16'd1;
          if (w_next == S_RESP) begin
            r_cyc      <= 1'b0;
            r_we_o     <= 1'b0;
            r_cnt      <= 2'd0;
            r_tx_valid <= 1'b1;
            // Ack has priority over a timeout on the same edge.
            if (ack_i) begin
              r_ok      <= 1'b1;
              r_resp    <= dat_i;
              r_tx_data <= r_we ? 8'h4B : dat_i[31:24];
            end else begin
              r_ok      <= 1'b0;
              r_tx_data <= 8'h45;
            end
          end
        end
        S_RESP: begin
          if (w_tx_hs) begin
            r_tx_valid <= 1'b0;
            r_cnt      <= r_cnt + 2'd1;
            r_resp     <= {r_resp[23:0], 8'h00};
          end else if (!r_tx_valid) begin
            // The byte after a handshake goes out one cycle later, so
            // there is no combinational path from tx_ready.
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_resp[31:24];
          end
        end
        default: ;
      endcase
      if (w_next == S_BUS && r_state != S_BUS) begin
        r_cyc  <= 1'b1;
        r_we_o <= r_we;
        r_tmo  <= 16'd0;
      end
    end
  end

endmodule

// File: doc/wb_host_master.md
# wb_host_master

Byte-stream-to-Wishbone bridge: it lets an external host act as a Wishbone initiator alongside the CPU. It takes command bytes from a UART receive byte interface and performs 32-bit single-beat reads and writes on the system bus. It returns result bytes to a UART transmit byte interface. It sits beside the CPU as a second master, behind the bus arbiter, and is used for debug loading, memory inspection and peripheral poking.

## Interface
Parameters:
- TIMEOUT, 1024: cycles `cyc_o` may stay asserted without `ack_i` before the transaction is abandoned. Range 2..65535.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- rx_data  in  8  received byte.
- rx_valid  in  1  `rx_data` valid.
- rx_ready  out  1  byte accepted when `rx_valid & rx_ready`.
- tx_data  out  8  response byte.
- tx_valid  out  1  `tx_data` valid.
- tx_ready  in  1  byte consumed when `tx_valid & tx_ready`.
- adr_o  out  32  Wishbone byte address; bits [1:0] always 0.
- dat_o  out  32  write data.
- dat_i  in  32  read data.
- sel_o  out  4  byte selects; always 4'hf while `cyc_o` is high, 4'h0 otherwise.
- we_o  out  1  write enable.
- cyc_o  out  1  bus cycle.
- stb_o  out  1  strobe; identical to `cyc_o`.
- ack_i  in  1  slave acknowledge.
- busy  out  1  high in every state except IDLE.

## Operation
- Protocol; all multi-byte fields are MSB first:
  - Read: 0x52 ('R'), A3 A2 A1 A0. Reply on success is D3 D2 D1 D0.
  - Write: 0x57 ('W'), A3 A2 A1 A0, D3 D2 D1 D0. Reply on success is 0x4B ('K').
  - Timeout on either command: reply is the single byte 0x45 ('E').
- Address bytes [1:0] are discarded; `adr_o` = {A[31:2], 2'b00}.
- Any byte other than 0x52 or 0x57 received in IDLE is consumed and dropped, with no reply.
- States:
  - IDLE: `rx_ready`=1. On 'R' or 'W', latch we (1 for 'W'), clear the byte count, go to ADDR.
  - ADDR: `rx_ready`=1. Shift each byte into the address register. After the 4th byte, go to DATA if we=1, else to BUS.
  - DATA: `rx_ready`=1. Shift 4 bytes into the write-data register, then go to BUS.
  - BUS: `cyc_o`=`stb_o`=1 and `we_o`=we. `rx_ready`=0.
    - On `ack_i`=1: latch `dat_i` into the response register and go to RESP with result OK.
    - When the timeout counter reaches TIMEOUT-1 with no ack: go to RESP with result ERR.
  - RESP: `rx_ready`=0. Emit the reply bytes. Return to IDLE after the last handshake.
- The 16-bit timeout counter clears on entry to BUS and increments each BUS cycle.
- All datapath registers are 32-bit. The byte counter is 2 bits and wraps, and the wrap marks field completion.

## Timing
- Reset values:
  - `cyc_o`, `stb_o`, `we_o`, `tx_valid`, `busy` = 0.
  - `sel_o` = 0, `adr_o` = 0, `dat_o` = 0, `tx_data` = 0.
  - `rx_ready` = 1 (IDLE).
- All outputs are registered except `rx_ready` and `sel_o`, which are decoded from state.
- BUS entry: `cyc_o` rises on the cycle after the handshake of the last command byte.
- BUS exit:
  - If `ack_i` is sampled high on edge N, `cyc_o` is low from edge N.
  - `tx_valid` rises on edge N with the first reply byte.
  - Bus occupancy on a zero-wait slave is therefore 1 cycle.
- Ack and timeout on the same edge: ack wins and the result is OK.
- A late ack after the timeout has fired is ignored, because `cyc_o` is already low.
- `tx_valid` holds with `tx_data` stable until `tx_ready`. The next byte is presented on the following cycle, so there is one byte per 2 cycles minimum, and no combinational path from `tx_ready`.
- `rx_valid` while `rx_ready`=0: the byte is not consumed. The upstream UART must hold or buffer it.
- Reset asserted mid-transaction:
  - On the next edge, `cyc_o` drops, `tx_valid` drops, and the state returns to IDLE.
  - Partial commands are discarded.
- Minimum full-read round trip, with zero-wait slave and `tx_ready` always 1: 5 rx cycles + 1 bus + 8 tx cycles.

## Test plan
- Read: send 52 00 00 10 04, slave returns DEADBEEF with 0 wait states.
  - Required: `adr_o`=0x00001004, `we_o`=0, `sel_o`=f, and `cyc_o` high for exactly 1 cycle.
  - Required tx bytes: DE AD BE EF.
- Write: send 57 80 00 00 07 12 34 56 78, slave acks after 3 waits.
  - Required: `adr_o`=0x80000004, `dat_o`=0x12345678, `we_o`=1, `cyc_o` high for 4 cycles.
  - Required tx byte: 4B.
- Timeout: TIMEOUT=16, send a read, slave never acks.
  - Required: `cyc_o` high for exactly 16 cycles, then tx 45, then `busy`=0.
  - A subsequent read still works.
- Ack at the limit: ack on the final timeout cycle. Required: the OK data reply is sent, not 45.
- Garbage and backpressure:
  - Send 00 FF 52 then an address. Required: the first two bytes are dropped and the read completes.
  - Hold `tx_ready`=0 for 10 cycles. Required: `tx_data` is stable and `rx_ready`=0 throughout.
- Reset: assert `rst_i` for 1 cycle mid-BUS and mid-RESP.
  - Required: all outputs at reset values on the next edge.
  - A fresh command then completes correctly.
